// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the time-set controller: BCD digit width and limit,
// controller state encoding and field-select codes.
package time_set_ctrl_pkg;

    localparam int unsigned BCD_BIT_WIDTH = 4;
    localparam logic [BCD_BIT_WIDTH-1:0] NINE = 4'd9;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SET_HOUR = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_SEC  = 3'd3,
        ST_COMMIT   = 3'd4
    } state_t;

    localparam logic [1:0] FSEL_NONE = 2'd0;
    localparam logic [1:0] FSEL_HOUR = 2'd1;
    localparam logic [1:0] FSEL_MIN  = 2'd2;
    localparam logic [1:0] FSEL_SEC  = 2'd3;

endpackage

// File: rtl/time_set_ctrl_inc.sv
// Combinational two-digit BCD +1 with wrap to 00 after MAX_VAL.
module bcd2_wrap_inc
    import time_set_ctrl_pkg::*;
#(
    parameter logic [7:0] MAX_VAL = 8'h59
) (
    input  logic [BCD_BIT_WIDTH-1:0] i_hi,
    input  logic [BCD_BIT_WIDTH-1:0] i_lo,
    output logic [BCD_BIT_WIDTH-1:0] o_hi,
    output logic [BCD_BIT_WIDTH-1:0] o_lo
);

    // Increment low digit, carry into high digit at 9, wrap whole field at MAX_VAL
    always_comb begin
        o_hi = i_hi;
        o_lo = i_lo + 4'd1;
        if ({i_hi, i_lo} == MAX_VAL) begin
            o_hi = '0;
            o_lo = '0;
        end else if (i_lo == NINE) begin
            o_lo = '0;
            o_hi = i_hi + 4'd1;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set sequencing controller for the hh:mm:ss BCD counter chain.
// Optional feature macro: TIME_SET_BLINK_EN (blink toggles on ticks while editing).
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter logic [7:0] HOUR_MAX = 8'h23,
    parameter logic [7:0] MIN_MAX  = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_sec0,
    input  logic [3:0] cur_sec1,
    input  logic [3:0] cur_min0,
    input  logic [3:0] cur_min1,
    input  logic [3:0] cur_hour0,
    input  logic [3:0] cur_hour1,
    output logic       count_enable,
    output logic       load_value_enable,
    output logic [3:0] load_sec0,
    output logic [3:0] load_sec1,
    output logic [3:0] load_min0,
    output logic [3:0] load_min1,
    output logic [3:0] load_hour0,
    output logic [3:0] load_hour1,
    output logic [1:0] field_sel,
    output logic       blink
);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_sec0, r_sec1, r_min0, r_min1, r_hour0, r_hour1;
    logic [3:0] w_sec0, w_sec1, w_min0, w_min1, w_hour0, w_hour1;

    bcd2_wrap_inc #(.MAX_VAL(HOUR_MAX)) u_inc_hour (
        .i_hi(r_hour1), .i_lo(r_hour0), .o_hi(w_hour1), .o_lo(w_hour0)
    );
    bcd2_wrap_inc #(.MAX_VAL(MIN_MAX)) u_inc_min (
        .i_hi(r_min1), .i_lo(r_min0), .o_hi(w_min1), .o_lo(w_min0)
    );
    bcd2_wrap_inc #(.MAX_VAL(MIN_MAX)) u_inc_sec (
        .i_hi(r_sec1), .i_lo(r_sec0), .o_hi(w_sec1), .o_lo(w_sec0)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_next;
    end

    // Next-state and per-state outputs
    always_comb begin
        w_next            = r_state;
        count_enable      = 1'b0;
        load_value_enable = 1'b0;
        field_sel         = FSEL_NONE;
        case (r_state)
            ST_RUN: begin
                count_enable = tick_1hz;
                if (btn_mode) w_next = ST_SET_HOUR;
            end
            ST_SET_HOUR: begin
                field_sel = FSEL_HOUR;
                if (btn_mode) w_next = ST_SET_MIN;
            end
            ST_SET_MIN: begin
                field_sel = FSEL_MIN;
                if (btn_mode) w_next = ST_SET_SEC;
            end
            ST_SET_SEC: begin
                field_sel = FSEL_SEC;
                if (btn_mode) w_next = ST_COMMIT;
            end
            ST_COMMIT: begin
                load_value_enable = 1'b1;
                w_next            = ST_RUN;
            end
            default: w_next = ST_RUN;
        endcase
    end

    // Shadow digits: snapshot on entry to set mode, increment selected field (mode wins over inc)
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_hour1, r_hour0, r_min1, r_min0, r_sec1, r_sec0} <= '0;
        end else begin
            case (r_state)
                ST_RUN: if (btn_mode) begin
                    {r_hour1, r_hour0} <= {cur_hour1, cur_hour0};
                    {r_min1, r_min0}   <= {cur_min1, cur_min0};
                    {r_sec1, r_sec0}   <= {cur_sec1, cur_sec0};
                end
                ST_SET_HOUR: if (btn_inc && !btn_mode) {r_hour1, r_hour0} <= {w_hour1, w_hour0};
                ST_SET_MIN:  if (btn_inc && !btn_mode) {r_min1, r_min0}   <= {w_min1, w_min0};
                ST_SET_SEC:  if (btn_inc && !btn_mode) {r_sec1, r_sec0}   <= {w_sec1, w_sec0};
                default: ;
            endcase
        end
    end

    assign load_sec0  = r_sec0;
    assign load_sec1  = r_sec1;
    assign load_min0  = r_min0;
    assign load_min1  = r_min1;
    assign load_hour0 = r_hour0;
    assign load_hour1 = r_hour1;

`ifdef TIME_SET_BLINK_EN
    logic r_blink;
    logic w_in_set;

    assign w_in_set = (r_state == ST_SET_HOUR) || (r_state == ST_SET_MIN) || (r_state == ST_SET_SEC);

    // Blink toggles per tick while editing; held at 0 outside set mode so entry starts cleared
    always_ff @(posedge clk) begin
        if (rst)                 r_blink <= 1'b0;
        else if (!w_in_set)      r_blink <= 1'b0;
        else if (tick_1hz)       r_blink <= ~r_blink;
    end

    assign blink = r_blink & w_in_set;
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed scenarios with literal
// expectations plus randomized pulses checked every cycle against an
// integer-arithmetic model of the time-set sequence.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
    logic [3:0] cur_sec0 = '0, cur_sec1 = '0, cur_min0 = '0, cur_min1 = '0, cur_hour0 = '0, cur_hour1 = '0;
    logic       count_enable, load_value_enable, blink;
    logic [3:0] load_sec0, load_sec1, load_min0, load_min1, load_hour0, load_hour1;
    logic [1:0] field_sel;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // model: phase 0 run, 1 hour, 2 min, 3 sec, 4 commit; shadow kept as plain integers
    int m_phase = 0, m_h = 0, m_m = 0, m_s = 0;
    bit m_blink = 1'b0;

    time_set_ctrl #(.HOUR_MAX(8'h23), .MIN_MAX(8'h59)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_sec0(cur_sec0), .cur_sec1(cur_sec1), .cur_min0(cur_min0), .cur_min1(cur_min1),
        .cur_hour0(cur_hour0), .cur_hour1(cur_hour1),
        .count_enable(count_enable), .load_value_enable(load_value_enable),
        .load_sec0(load_sec0), .load_sec1(load_sec1), .load_min0(load_min0), .load_min1(load_min1),
        .load_hour0(load_hour0), .load_hour1(load_hour1),
        .field_sel(field_sel), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic int inc_wrap(input int v, input int mx);
        return (v == mx) ? 0 : v + 1;
    endfunction

    // reference model advances on every clock edge using the inputs present at that edge
    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_h = 0; m_m = 0; m_s = 0; m_blink = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    m_blink = 1'b0;
                    if (btn_mode) begin
                        m_h = cur_hour1 * 10 + cur_hour0;
                        m_m = cur_min1 * 10 + cur_min0;
                        m_s = cur_sec1 * 10 + cur_sec0;
                        m_phase = 1;
                    end
                end
                1, 2, 3: begin
                    if (tick_1hz) m_blink = ~m_blink;
                    if (btn_mode) m_phase = m_phase + 1;
                    else if (btn_inc) begin
                        if (m_phase == 1)      m_h = inc_wrap(m_h, 23);
                        else if (m_phase == 2) m_m = inc_wrap(m_m, 59);
                        else                   m_s = inc_wrap(m_s, 59);
                    end
                end
                default: begin
                    m_blink = 1'b0;
                    m_phase = 0;
                end
            endcase
        end
    end

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            bit in_set;
            in_set = (m_phase >= 1 && m_phase <= 3);
            chk("count_enable", {7'd0, count_enable}, {7'd0, (m_phase == 0) && tick_1hz});
            chk("load_value_enable", {7'd0, load_value_enable}, {7'd0, m_phase == 4});
            chk("field_sel", {6'd0, field_sel}, in_set ? 8'(m_phase) : 8'd0);
            chk("load_hour", {load_hour1, load_hour0}, {4'(m_h / 10), 4'(m_h % 10)});
            chk("load_min", {load_min1, load_min0}, {4'(m_m / 10), 4'(m_m % 10)});
            chk("load_sec", {load_sec1, load_sec0}, {4'(m_s / 10), 4'(m_s % 10)});
`ifdef TIME_SET_BLINK_EN
            chk("blink", {7'd0, blink}, {7'd0, m_blink && in_set});
`else
            chk("blink", {7'd0, blink}, 8'd0);
`endif
        end
    end

    // one clock with the given pulses, pulses cleared #1 after the edge
    task automatic step(input bit m, input bit inc, input bit tk);
        btn_mode = m; btn_inc = inc; tick_1hz = tk;
        @(posedge clk); #1;
        btn_mode = 1'b0; btn_inc = 1'b0; tick_1hz = 1'b0;
    endtask

    task automatic set_cur(input int h, input int mi, input int s);
        cur_hour1 = 4'(h / 10); cur_hour0 = 4'(h % 10);
        cur_min1 = 4'(mi / 10); cur_min0 = 4'(mi % 10);
        cur_sec1 = 4'(s / 10);  cur_sec0 = 4'(s % 10);
    endtask

    task automatic chk_load(input string nm, input logic [23:0] exp);
        chk({nm, "_hour"}, {load_hour1, load_hour0}, exp[23:16]);
        chk({nm, "_min"},  {load_min1, load_min0},   exp[15:8]);
        chk({nm, "_sec"},  {load_sec1, load_sec0},   exp[7:0]);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // reset state
        chk("rst_field_sel", {6'd0, field_sel}, 8'd0);
        chk("rst_lve", {7'd0, load_value_enable}, 8'd0);
        chk("rst_blink", {7'd0, blink}, 8'd0);
        chk_load("rst_load", 24'h00_00_00);

        // three ticks in RUN: count_enable follows tick in the same cycle
        for (int unsigned i = 0; i < 3; i++) begin
            tick_1hz = 1'b1; #1;
            chk("run_tick_ce", {7'd0, count_enable}, 8'd1);
            chk("run_tick_lve", {7'd0, load_value_enable}, 8'd0);
            @(posedge clk); #1 tick_1hz = 1'b0;
            step(0, 0, 0);
        end

        // enter set mode with snapshot 12:34:56
        set_cur(12, 34, 56);
        step(1, 0, 0);
        set_cur(1, 1, 1);
        chk("set_field_hour", {6'd0, field_sel}, 8'd1);
        chk_load("snapshot", 24'h12_34_56);
        tick_1hz = 1'b1; #1;
        chk("set_tick_ce", {7'd0, count_enable}, 8'd0);
        @(posedge clk); #1 tick_1hz = 1'b0;

        // hour 12 -> 23, then wrap to 00
        repeat (11) step(0, 1, 0);
        chk("hour_at_23", {load_hour1, load_hour0}, 8'h23);
        step(0, 1, 0);
        chk("hour_wrap", {load_hour1, load_hour0}, 8'h00);
        step(1, 0, 0);
        chk("field_min", {6'd0, field_sel}, 8'd2);
        // minutes 34 -> 59 -> 00
        repeat (25) step(0, 1, 0);
        chk("min_at_59", {load_min1, load_min0}, 8'h59);
        step(0, 1, 0);
        chk("min_wrap", {load_min1, load_min0}, 8'h00);
        // mode and inc together: advance, minutes untouched
        step(1, 1, 0);
        chk("mode_wins_field", {6'd0, field_sel}, 8'd3);
        chk("mode_wins_min", {load_min1, load_min0}, 8'h00);
        // seconds 56 -> 09 -> 10
        repeat (13) step(0, 1, 0);
        chk("sec_at_09", {load_sec1, load_sec0}, 8'h09);
        step(0, 1, 0);
        chk("sec_carry", {load_sec1, load_sec0}, 8'h10);
        step(1, 0, 0);
        chk("commit1_lve", {7'd0, load_value_enable}, 8'd1);
        step(0, 0, 0);
        chk("after_commit1", {7'd0, load_value_enable}, 8'd0);

        // edit to 07:00:45 and commit
        set_cur(6, 59, 44);
        step(1, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        chk("commit_lve", {7'd0, load_value_enable}, 8'd1);
        chk("commit_field", {6'd0, field_sel}, 8'd0);
        chk_load("commit_load", 24'h07_00_45);
        tick_1hz = 1'b1; #1;
        chk("commit_tick_ce", {7'd0, count_enable}, 8'd0);
        @(posedge clk); #1 tick_1hz = 1'b0;
        chk("back_run_lve", {7'd0, load_value_enable}, 8'd0);
        chk("back_run_field", {6'd0, field_sel}, 8'd0);

        // reset while editing seconds
        step(1, 0, 0);
        step(0, 0, 1);
        step(1, 0, 0);
        step(1, 0, 1);
        chk("pre_rst_field", {6'd0, field_sel}, 8'd3);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("rst_mid_field", {6'd0, field_sel}, 8'd0);
        chk("rst_mid_lve", {7'd0, load_value_enable}, 8'd0);
        chk("rst_mid_blink", {7'd0, blink}, 8'd0);
        step(0, 0, 0);
        chk("rst_mid_no_load", {7'd0, load_value_enable}, 8'd0);

        // randomized pulses, occasional reset and new live time
        for (int unsigned i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0)
                set_cur($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            rst = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
            rst = 1'b0;
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
